// File: rtl/pipe_drawer.sv
// pipe_drawer: on each game tick erases the old pipe and draws the new one as a
// one-pixel-per-cycle plot stream. Define PIPE_DRAWER_ERASE_EN to enable the erase pass.
module pipe_drawer #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         PIPE_W      = 4,
  parameter int         GAP_H       = 30,
  parameter logic [2:0] PIPE_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic [8:0] pipe_x,
  input  logic [6:0] pipe_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int                OFF_W      = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;
  localparam logic [8:0]        SCREEN_W_C = 9'(SCREEN_W);
  localparam logic [6:0]        ROW_LAST   = 7'(SCREEN_H - 1);
  localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'(PIPE_W - 1);
  localparam logic [7:0]        GAP_H_C    = 8'(GAP_H);

`ifdef PIPE_DRAWER_ERASE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ERASE = 2'd1, S_DRAW = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd2, S_DONE = 2'd3} state_t;
`endif

  state_t           state_r, state_s, first_s;
  logic             tick_meta_r, tick_sync_r, tick_prev_r, tick_edge_s;
  logic [8:0]       new_x_r, shadow_x_r;
  logic [6:0]       new_y_r, shadow_y_r;
  logic             pending_r, start_s, last_s;
  logic [6:0]       row_r;
  logic [OFF_W-1:0] off_r;
  logic [8:0]       base_x_s, col_s;
  logic [7:0]       gap_end_s;
  logic [2:0]       colour_s;
  logic             active_s, draw_s, in_gap_s, pix_plot_s;
`ifdef PIPE_DRAWER_ERASE_EN
  logic [8:0]       old_x_r;
  logic             old_valid_r;
`endif

  // Synchronise game_tick and keep one delayed copy for rising-edge detection
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      tick_meta_r <= 1'b0;
      tick_sync_r <= 1'b0;
      tick_prev_r <= 1'b0;
    end else begin
      tick_meta_r <= game_tick;
      tick_sync_r <= tick_meta_r;
      tick_prev_r <= tick_sync_r;
    end
  end

  assign tick_edge_s = tick_sync_r & ~tick_prev_r;
  assign last_s      = (row_r == ROW_LAST) && (off_r == OFF_LAST);

`ifdef PIPE_DRAWER_ERASE_EN
  assign first_s = old_valid_r ? S_ERASE : S_DRAW;
`else
  assign first_s = S_DRAW;
`endif

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a tick landing in DONE chains straight into the next update
  always_comb begin
    state_s = state_r;
    start_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tick_edge_s) begin
          start_s = 1'b1;
          state_s = first_s;
        end else begin
          state_s = S_IDLE;
        end
      end
`ifdef PIPE_DRAWER_ERASE_EN
      S_ERASE: begin
        if (last_s) state_s = S_DRAW;
        else        state_s = S_ERASE;
      end
`endif
      S_DRAW: begin
        if (last_s) state_s = S_DONE;
        else        state_s = S_DRAW;
      end
      S_DONE: begin
        if (pending_r || tick_edge_s) begin
          start_s = 1'b1;
          state_s = first_s;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Capture, shadow/pending bookkeeping and the row-major scan counters
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      new_x_r     <= 9'd0;
      new_y_r     <= 7'd0;
      shadow_x_r  <= 9'd0;
      shadow_y_r  <= 7'd0;
      pending_r   <= 1'b0;
      overrun     <= 1'b0;
      row_r       <= 7'd0;
      off_r       <= '0;
`ifdef PIPE_DRAWER_ERASE_EN
      old_x_r     <= 9'd0;
      old_valid_r <= 1'b0;
`endif
    end else begin
      if (start_s && (state_r == S_DONE) && pending_r) begin
        new_x_r <= shadow_x_r;
        new_y_r <= shadow_y_r;
      end else if (start_s) begin
        new_x_r <= pipe_x;
        new_y_r <= pipe_y;
      end

      if (tick_edge_s && !start_s) begin
        if (pending_r) begin
          overrun <= 1'b1;
        end else begin
          pending_r  <= 1'b1;
          shadow_x_r <= pipe_x;
          shadow_y_r <= pipe_y;
        end
      end else if (start_s && pending_r) begin
        pending_r <= 1'b0;
        if (tick_edge_s) overrun <= 1'b1;
      end

      if (state_s != state_r) begin
        row_r <= 7'd0;
        off_r <= '0;
      end else if (active_s) begin
        if (off_r == OFF_LAST) begin
          off_r <= '0;
          row_r <= row_r + 7'd1;
        end else begin
          off_r <= off_r + 1'b1;
        end
      end

`ifdef PIPE_DRAWER_ERASE_EN
      if ((state_r == S_DRAW) && last_s) begin
        old_x_r     <= new_x_r;
        old_valid_r <= 1'b1;
      end
`endif
    end
  end

  // Pixel generation for the current scan position
  always_comb begin
    base_x_s = new_x_r;
    colour_s = BG_COLOUR;
    active_s = 1'b0;
    draw_s   = 1'b0;
    case (state_r)
`ifdef PIPE_DRAWER_ERASE_EN
      S_ERASE: begin
        base_x_s = old_x_r;
        colour_s = BG_COLOUR;
        active_s = 1'b1;
      end
`endif
      S_DRAW: begin
        colour_s = PIPE_COLOUR;
        active_s = 1'b1;
        draw_s   = 1'b1;
      end
      default: begin
        active_s = 1'b0;
      end
    endcase
    col_s      = base_x_s + 9'(off_r);
    // 8-bit gap end cannot wrap, so a gap running off the bottom is simply clipped
    gap_end_s  = {1'b0, new_y_r} + GAP_H_C;
    in_gap_s   = (row_r >= new_y_r) && ({1'b0, row_r} < gap_end_s);
    pix_plot_s = active_s && (col_s < SCREEN_W_C) && !(draw_s && in_gap_s);
  end

  // Registered plot stream and status; coordinates hold while plot is low
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= pix_plot_s;
      busy <= (state_s != S_IDLE);
      done <= (state_r == S_DONE);
      if (pix_plot_s) begin
        vga_x      <= col_s[7:0];
        vga_y      <= row_r;
        vga_colour <= colour_s;
      end
    end
  end

endmodule

// File: tb/tb_pipe_drawer.sv
// Scoreboard bench for pipe_drawer: a list-based pipe model queues expected pixels
// and done times; a forked monitor compares them as the DUT presents them.
module tb_pipe_drawer;

  localparam int N = 480;
`ifdef PIPE_DRAWER_ERASE_EN
  localparam int ERASE_EN = 1;
`else
  localparam int ERASE_EN = 0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       game_tick;
  logic [8:0] pipe_x;
  logic [6:0] pipe_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy, done, overrun;

  pix_t exp_q[$];
  int   exp_done_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   plot_seen = 0;
  int   done_seen = 0;
  int   m_old_x = 0;
  bit   m_old_valid = 1'b0;

  pipe_drawer dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .game_tick  (game_tick),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    pix_t e;
    forever begin
      @(negedge CLOCK_50);
      if (resetn) begin
        if (plot) begin
          plot_seen++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", vga_x, vga_y, vga_colour);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if ({vga_x, vga_y, vga_colour} != e) begin
              fails++;
              $display("FAIL pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                       vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
          end
        end
        if (done) begin
          done_seen++;
          if (exp_done_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
          end else begin
            check("done_cycle", cyc, exp_done_q.pop_front());
          end
        end
      end
    end
  endtask

  // Reference: list every pixel of the erase (old rectangle) and draw (pipe minus gap)
  task automatic model_update(input int x, input int y, output int passes);
    pix_t p;
    passes = 1;
    if (ERASE_EN != 0 && m_old_valid) begin
      passes = 2;
      for (int r = 0; r < 120; r++)
        for (int o = 0; o < 4; o++)
          if (m_old_x + o < 160) begin
            p.x = 8'(m_old_x + o); p.y = 7'(r); p.c = 3'b000;
            exp_q.push_back(p);
          end
    end
    for (int r = 0; r < 120; r++)
      for (int o = 0; o < 4; o++)
        if ((x + o < 160) && !(r >= y && r < y + 30)) begin
          p.x = 8'(x + o); p.y = 7'(r); p.c = 3'b010;
          exp_q.push_back(p);
        end
    m_old_x = x;
    m_old_valid = 1'b1;
  endtask

  task automatic send_tick(input int x, input int y, output int t);
    @(posedge CLOCK_50); #1;
    t = cyc;
    pipe_x = 9'(x);
    pipe_y = 7'(y);
    game_tick = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1 game_tick = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && k < 4000) begin
      @(posedge CLOCK_50);
      k++;
    end
    if (k >= 4000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pixels / %0d dones outstanding, expected 0",
               exp_q.size(), exp_done_q.size());
      exp_q.delete();
      exp_done_q.delete();
    end
    repeat (4) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic run_update(input string nm, input int x, input int y, input int exp_plots);
    int t, p, p0, d0;
    p0 = plot_seen;
    d0 = done_seen;
    model_update(x, y, p);
    send_tick(x, y, t);
    exp_done_q.push_back(t + 4 + p * N);
    wait_drain();
    if (exp_plots >= 0) check({nm, "_plots"}, plot_seen - p0, exp_plots);
    check({nm, "_dones"}, done_seen - d0, 1);
  endtask

  initial begin
    int ta, tb, tc, pa, pb, d0, da;
    game_tick = 1'b0;
    pipe_x = 9'd0;
    pipe_y = 7'd0;
    resetn = 1'b1;
    fork
      monitor();
    join_none
    #2 resetn = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);

    run_update("first_draw", 50, 40, 360);
    run_update("erase_draw", 49, 40, (ERASE_EN != 0) ? 840 : 360);
    run_update("clip_158", 158, 40, (ERASE_EN != 0) ? 480 + 180 : 180);
    run_update("clip_160", 160, 40, (ERASE_EN != 0) ? 240 : 0);
    run_update("gap_bottom", 20, 100, 400);
    check("no_overrun", overrun, 0);

    for (int i = 0; i < 6; i++)
      run_update("random", int'($urandom_range(0, 160)), int'($urandom_range(0, 127)), -1);

    // Three ticks in one update: second is shadowed, third is dropped
    d0 = done_seen;
    model_update(30, 50, pa);
    send_tick(30, 50, ta);
    da = ta + 4 + pa * N;
    exp_done_q.push_back(da);
    repeat (100) @(posedge CLOCK_50);
    model_update(70, 10, pb);
    send_tick(70, 10, tb);
    exp_done_q.push_back(da + pb * N + 1);
    repeat (100) @(posedge CLOCK_50);
    send_tick(90, 5, tc);
    wait_drain();
    check("busy_dones", done_seen - d0, 2);
    check("busy_overrun", overrun, 1);

    // Reset in the middle of a draw pass
    model_update(50, 40, pa);
    send_tick(50, 40, ta);
    exp_done_q.push_back(ta + 4 + pa * N);
    repeat (((ERASE_EN != 0) ? N : 0) + 40) @(posedge CLOCK_50);
    #1;
    check("busy_before_reset", busy, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    exp_done_q.delete();
    m_old_valid = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 resetn = 1'b1;
    check("mid_rst_overrun", overrun, 0);
    run_update("after_reset", 60, 40, 360);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_drawer.md
# pipe_drawer

Renders one scrolling pipe into the VGA frame buffer. On each game tick it erases the previous pipe rectangle, then draws the new one from the pipe's x position and opening y coordinate. The pipe position comes from the pipe register stage. Output is a one-pixel-per-cycle plot stream (x, y, colour, plot) that feeds the VGA adapter's write port.

## Interface

Parameters:
- SCREEN_W, 160, visible columns; pixels with x ≥ SCREEN_W are never plotted.
- SCREEN_H, 120, visible rows.
- PIPE_W, 4, pipe width in pixels.
- GAP_H, 30, height of the opening; the opening spans rows pipe_y to pipe_y+GAP_H-1.
- PIPE_COLOUR, 3'b010, draw colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- game_tick  in  1  game-rate strobe (level); sampled in the CLOCK_50 domain, rising edge detected.
- pipe_x  in  9  pipe left edge; 0..160, where 160 is off-screen.
- pipe_y  in  7  top row of the opening.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  pixel colour.
- plot  out  1  write-enable for the current pixel.
- busy  out  1  high while ERASE or DRAW is active.
- done  out  1  one-cycle pulse when a frame update completes.
- overrun  out  1  sticky; set when a tick is dropped.

## Operation

- **Tick capture.** game_tick passes through a 2-flop synchroniser and a rising-edge detector. On a detected edge, pipe_x and pipe_y are captured into new_x and new_y.
- **States.** IDLE, ERASE, DRAW, DONE.
  - IDLE → ERASE on a tick when old_valid=1.
  - IDLE → DRAW on a tick when old_valid=0.
  - ERASE → DRAW after its pass.
  - DRAW → DONE after its pass.
  - DONE → IDLE, or → ERASE if pending=1 (pending clears on that transition).
- **Pass scan.** Row-major: row 0..SCREEN_H-1, and within each row column offset 0..PIPE_W-1. One position per cycle, so N = SCREEN_H×PIPE_W = 480 cycles per pass.
- **ERASE.** Uses old_x. plot=1 for every position with column < SCREEN_W. Colour is BG_COLOUR. All rows are written, including the gap.
- **DRAW.** Uses new_x and new_y. plot=1 only where column < SCREEN_W and the row is outside the gap. Colour is PIPE_COLOUR.
  - Gap membership: row ≥ new_y and row < new_y+GAP_H. The sum is computed 8 bits wide, so there is no wrap; a gap extending past SCREEN_H is clipped.
- **Column arithmetic.** Column = x + offset, computed 9 bits wide. Compare against SCREEN_W before truncating to the 8-bit vga_x.
- **End of DRAW.** old_x ← new_x and old_valid ← 1.
- **Tick while busy or in DONE.** If pending=0, set pending=1 and capture the inputs into a one-deep shadow register. A tick arriving while pending=1 is dropped and sets overrun (cleared only by reset).
- **Pending update.** Its ERASE uses the just-drawn new_x as old_x. The shadow values become new_x and new_y.
- **Reset** (asynchronous, any state):
  - State → IDLE.
  - old_valid, pending, overrun, busy, done, plot → 0.
  - vga_x, vga_y, vga_colour → 0.
  - The next tick therefore performs DRAW only.

## Timing

- **Tick to capture.** game_tick rising between edges E-1 and E; capture occurs at edge E+2.
- **Start of a pass.** At the capture edge (C), the state enters ERASE/DRAW and counters reset to 0. busy is registered high from C.
- **Pixel output.** Pixel k of a pass is presented on vga_x, vga_y, vga_colour and plot during the cycle after edge C+1+k. All four outputs are registered together.
- **Between passes.** ERASE and DRAW are back-to-back, with no idle cycle.
- **End of update.** done=1 for exactly one cycle, immediately after the last DRAW pixel. busy falls in that same cycle.
- **Total update time.** DRAW only: 1+N+1 cycles. ERASE then DRAW: 1+2N+1 cycles.
- **Idle outputs.** When plot=0, vga_x, vga_y and vga_colour hold their last values.

## Configuration

- **PIPE_DRAWER_ERASE_EN defined:** ERASE state present, behaviour as above.
- **PIPE_DRAWER_ERASE_EN undefined:**
  - ERASE, old_x and old_valid are removed.
  - Every update is DRAW only, taking 1+N+1 cycles.
  - Clearing the screen is the caller's responsibility.

## Test plan

- **First draw after reset.** Reset, then tick with pipe_x=50, pipe_y=40.
  - No ERASE.
  - Exactly 360 plots: x 50..53, y ∉ 40..69, colour 010.
  - One done pulse, 482 cycles after capture.
- **Erase then draw.** Follow-up tick with pipe_x=49, pipe_y=40.
  - 480 BG plots at x 50..53, all y.
  - Then 360 PIPE plots at x 49..52.
  - done after 962 cycles.
- **Right-edge clipping.** pipe_x=158 → only x 158 and 159 plotted, 180 DRAW plots. pipe_x=160 → zero DRAW plots, done still pulses.
- **Gap clipped at bottom.** pipe_y=100 → pipe rows 0..99 only, 400 plots; no wrap to rows 0..9 as gap.
- **Ticks during busy.**
  - Second tick during DRAW → a second update starts directly after DONE, using the shadowed values.
  - Third tick while pending → overrun=1, and exactly two done pulses total.
- **Reset mid-operation.** Assert resetn=0 mid-DRAW.
  - plot, busy and done go 0 immediately (asynchronously).
  - The next tick performs DRAW only, with no ERASE.
